// File: rtl/falling_block_ctrl_pkg.sv
// Shared types and constants for the falling-block sequencer.
package falling_block_ctrl_pkg;

  typedef logic [2:0] color_t;
  localparam color_t COLOR_NONE = 3'd0;

  localparam int BOARD_COLS = 10;
  localparam int BOARD_ROWS = 20;
  localparam int COL_W      = 4;
  localparam int ROW_W      = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPAWNQ,
    ST_WAIT,
    ST_MOVEQ,
    ST_FALLQ,
    ST_LOCK,
    ST_OVER
  } state_t;

  // States that own an outstanding board lookup.
  function automatic logic is_query_state(input state_t s);
    return (s == ST_SPAWNQ) || (s == ST_MOVEQ) || (s == ST_FALLQ);
  endfunction

endpackage

// File: rtl/falling_block_ctrl_edge_pending.sv
// Rising-edge detector that latches a pending flag until cleared.
// A new edge arriving in the same cycle as the clear is kept.
module edge_pending (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_level,
  input  logic i_clear,
  output logic o_pending
);

  logic r_prev;
  logic r_pending;
  logic w_rise;

  assign w_rise    = i_level & ~r_prev;
  assign o_pending = r_pending;

  // Track the previous level and hold the pending flag.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_prev    <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_prev    <= i_level;
      r_pending <= (r_pending & ~i_clear) | w_rise;
    end
  end

endmodule

// File: rtl/falling_block_ctrl.sv
// Falling-block sequencer: gravity, left/right moves, board queries,
// lock records and respawn for the single active Tetris cell.
// Optional feature macro: FALLING_BLOCK_SOFT_DROP_EN adds a soft_drop
// input that makes every frame tick a gravity step.
//
// state  | meaning
// IDLE   | no game running, waiting for start
// SPAWNQ | querying the spawn cell
// WAIT   | cell falling, waiting for a frame tick
// MOVEQ  | querying the left/right target cell
// FALLQ  | querying the cell below
// LOCK   | one-cycle lock record, then respawn
// OVER   | spawn was blocked, waiting for start
module falling_block_ctrl
  import falling_block_ctrl_pkg::*;
#(
  parameter int BUS_WIDTH      = 11,
  parameter int COLS           = BOARD_COLS,
  parameter int ROWS           = BOARD_ROWS,
  parameter int FIELD_X        = 240,
  parameter int FIELD_Y        = 80,
  parameter int BLOCK_SIZE     = 16,
  parameter int SPAWN_COL      = 4,
  parameter int GRAVITY_FRAMES = 30
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 frame_tick,
  input  logic                 left,
  input  logic                 right,
`ifdef FALLING_BLOCK_SOFT_DROP_EN
  input  logic                 soft_drop,
`endif
  input  color_t               next_color,
  output logic                 query_valid,
  output logic [COL_W-1:0]     query_col,
  output logic [ROW_W-1:0]     query_row,
  input  logic                 query_done,
  input  logic                 query_occupied,
  output logic [BUS_WIDTH-1:0] x_pos,
  output logic [BUS_WIDTH-1:0] y_pos,
  output color_t               color,
  output logic                 active,
  output logic                 lock_valid,
  output logic [COL_W-1:0]     lock_col,
  output logic [ROW_W-1:0]     lock_row,
  output color_t               lock_color,
  output logic                 game_over
);

  localparam int GRAV_W = $clog2(GRAVITY_FRAMES + 1);
  localparam logic [COL_W-1:0]     SPAWN_C = COL_W'(SPAWN_COL);
  localparam logic [COL_W-1:0]     LAST_C  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]     LAST_R  = ROW_W'(ROWS - 1);
  localparam logic [GRAV_W-1:0]    GRAV_N  = GRAV_W'(GRAVITY_FRAMES);
  localparam logic [BUS_WIDTH-1:0] X_RST   = BUS_WIDTH'(FIELD_X + SPAWN_COL * BLOCK_SIZE);
  localparam logic [BUS_WIDTH-1:0] Y_RST   = BUS_WIDTH'(FIELD_Y);

  state_t               r_state, w_state_next;
  logic [COL_W-1:0]     r_col, w_col_next;
  logic [ROW_W-1:0]     r_row, w_row_next;
  color_t               r_color, w_color_next;
  logic [GRAV_W-1:0]    r_grav_cnt, w_grav_next;
  logic                 r_fall_due, w_fall_due_next;
  logic [COL_W-1:0]     r_qcol, w_qcol_next;
  logic [ROW_W-1:0]     r_qrow, w_qrow_next;
  logic                 r_game_over, w_game_over_next;
  logic                 r_query_valid;
  logic [BUS_WIDTH-1:0] r_x_pos, r_y_pos;

  logic                 w_left_pend, w_right_pend, w_pend_clear;
  logic                 w_qdone, w_soft, w_due_now;
  logic [GRAV_W-1:0]    w_grav_inc;
  logic                 w_move_ok;
  logic [COL_W-1:0]     w_move_col;
  logic                 w_do_fall;
  logic [COL_W-1:0]     w_fall_col;

`ifdef FALLING_BLOCK_SOFT_DROP_EN
  assign w_soft = soft_drop;
`else
  assign w_soft = 1'b0;
`endif

  edge_pending u_left_pend (
    .i_clock  (clock),
    .i_reset  (reset),
    .i_level  (left),
    .i_clear  (w_pend_clear),
    .o_pending(w_left_pend)
  );

  edge_pending u_right_pend (
    .i_clock  (clock),
    .i_reset  (reset),
    .i_level  (right),
    .i_clear  (w_pend_clear),
    .o_pending(w_right_pend)
  );

  // Responses only count while a request is actually outstanding.
  assign w_qdone    = query_done & r_query_valid;
  assign w_grav_inc = r_grav_cnt + 1'b1;
  assign w_due_now  = (w_grav_inc == GRAV_N) | w_soft;

  // Resolve the requested side move; both pressed or off-board means no move.
  always_comb begin
    w_move_ok  = 1'b0;
    w_move_col = r_col;
    if (w_left_pend && !w_right_pend && (r_col != '0)) begin
      w_move_ok  = 1'b1;
      w_move_col = r_col - 1'b1;
    end else if (w_right_pend && !w_left_pend && (r_col != LAST_C)) begin
      w_move_ok  = 1'b1;
      w_move_col = r_col + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state and datapath next values; the fall check is shared by WAIT and MOVEQ.
  always_comb begin
    w_state_next     = r_state;
    w_col_next       = r_col;
    w_row_next       = r_row;
    w_color_next     = r_color;
    w_grav_next      = r_grav_cnt;
    w_fall_due_next  = r_fall_due;
    w_qcol_next      = r_qcol;
    w_qrow_next      = r_qrow;
    w_game_over_next = r_game_over;
    w_pend_clear     = 1'b0;
    w_do_fall        = 1'b0;
    w_fall_col       = r_col;

    case (r_state)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          w_state_next     = ST_SPAWNQ;
          w_game_over_next = 1'b0;
          w_color_next     = next_color;
          w_col_next       = SPAWN_C;
          w_row_next       = '0;
          w_qcol_next      = SPAWN_C;
          w_qrow_next      = '0;
        end
      end
      ST_SPAWNQ: begin
        if (w_qdone) begin
          if (query_occupied) begin
            w_state_next     = ST_OVER;
            w_game_over_next = 1'b1;
          end else begin
            w_state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (frame_tick) begin
          w_pend_clear = 1'b1;
          w_grav_next  = w_grav_inc;
          if (w_move_ok) begin
            w_state_next    = ST_MOVEQ;
            w_qcol_next     = w_move_col;
            w_qrow_next     = r_row;
            w_fall_due_next = w_due_now;
          end else if (w_due_now) begin
            w_do_fall = 1'b1;
          end
        end
      end
      ST_MOVEQ: begin
        if (w_qdone) begin
          if (!query_occupied) begin
            w_col_next = r_qcol;
            w_fall_col = r_qcol;
          end
          if (r_fall_due) w_do_fall = 1'b1;
          else            w_state_next = ST_WAIT;
        end
      end
      ST_FALLQ: begin
        if (w_qdone) begin
          if (query_occupied) begin
            w_state_next = ST_LOCK;
          end else begin
            w_row_next   = r_row + 1'b1;
            w_state_next = ST_WAIT;
          end
        end
      end
      ST_LOCK: begin
        w_state_next = ST_SPAWNQ;
        w_color_next = next_color;
        w_col_next   = SPAWN_C;
        w_row_next   = '0;
        w_qcol_next  = SPAWN_C;
        w_qrow_next  = '0;
      end
      default: w_state_next = ST_IDLE;
    endcase

    if (w_do_fall) begin
      w_grav_next = '0;
      if (r_row == LAST_R) begin
        w_state_next = ST_LOCK;
      end else begin
        w_state_next = ST_FALLQ;
        w_qcol_next  = w_fall_col;
        w_qrow_next  = r_row + 1'b1;
      end
    end
  end

  // Datapath registers; query_valid drops for one cycle after every answer,
  // so a MOVEQ answer that leads straight into FALLQ re-raises it a cycle later.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_col         <= SPAWN_C;
      r_row         <= '0;
      r_color       <= COLOR_NONE;
      r_grav_cnt    <= '0;
      r_fall_due    <= 1'b0;
      r_qcol        <= SPAWN_C;
      r_qrow        <= '0;
      r_game_over   <= 1'b0;
      r_query_valid <= 1'b0;
    end else begin
      r_col         <= w_col_next;
      r_row         <= w_row_next;
      r_color       <= w_color_next;
      r_grav_cnt    <= w_grav_next;
      r_fall_due    <= w_fall_due_next;
      r_qcol        <= w_qcol_next;
      r_qrow        <= w_qrow_next;
      r_game_over   <= w_game_over_next;
      r_query_valid <= w_qdone ? 1'b0 : is_query_state(w_state_next);
    end
  end

  // Pixel position follows the board position one cycle later.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_x_pos <= X_RST;
      r_y_pos <= Y_RST;
    end else begin
      r_x_pos <= BUS_WIDTH'(FIELD_X) + BUS_WIDTH'(r_col) * BUS_WIDTH'(BLOCK_SIZE);
      r_y_pos <= BUS_WIDTH'(FIELD_Y) + BUS_WIDTH'(r_row) * BUS_WIDTH'(BLOCK_SIZE);
    end
  end

  assign query_valid = r_query_valid;
  assign query_col   = r_qcol;
  assign query_row   = r_qrow;
  assign x_pos       = r_x_pos;
  assign y_pos       = r_y_pos;
  assign color       = r_color;
  assign active      = (r_state == ST_WAIT) || (r_state == ST_MOVEQ) ||
                       (r_state == ST_FALLQ) || (r_state == ST_LOCK);
  assign lock_valid  = (r_state == ST_LOCK);
  assign lock_col    = r_col;
  assign lock_row    = r_row;
  assign lock_color  = r_color;
  assign game_over   = r_game_over;

endmodule

// File: tb/tb_falling_block_ctrl.sv
// Directed bench for falling_block_ctrl (default build; soft_drop only
// when FALLING_BLOCK_SOFT_DROP_EN is defined).
module tb_falling_block_ctrl;
  import falling_block_ctrl_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        frame_tick = 1'b0;
  logic        left = 1'b0;
  logic        right = 1'b0;
`ifdef FALLING_BLOCK_SOFT_DROP_EN
  logic        soft_drop = 1'b0;
`endif
  color_t      next_color = 3'd0;
  logic        query_valid;
  logic [3:0]  query_col;
  logic [4:0]  query_row;
  logic        query_done = 1'b0;
  logic        query_occupied = 1'b0;
  logic [10:0] x_pos, y_pos;
  color_t      color;
  logic        active;
  logic        lock_valid;
  logic [3:0]  lock_col;
  logic [4:0]  lock_row;
  color_t      lock_color;
  logic        game_over;

  int checks = 0;
  int errors = 0;

  falling_block_ctrl dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .frame_tick    (frame_tick),
    .left          (left),
    .right         (right),
`ifdef FALLING_BLOCK_SOFT_DROP_EN
    .soft_drop     (soft_drop),
`endif
    .next_color    (next_color),
    .query_valid   (query_valid),
    .query_col     (query_col),
    .query_row     (query_row),
    .query_done    (query_done),
    .query_occupied(query_occupied),
    .x_pos         (x_pos),
    .y_pos         (y_pos),
    .color         (color),
    .active        (active),
    .lock_valid    (lock_valid),
    .lock_col      (lock_col),
    .lock_row      (lock_row),
    .lock_color    (lock_color),
    .game_over     (game_over)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_qv(input string tag);
    int n = 0;
    while (query_valid !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    chk({tag, "_qv_seen"}, query_valid, 1);
  endtask

  // Answer one board query after dly cycles, checking the request stays put.
  task automatic serve(input string tag, input logic occ, input int dly,
                       input int ecol, input int erow);
    wait_qv(tag);
    chk({tag, "_col"}, query_col, ecol);
    chk({tag, "_row"}, query_row, erow);
    for (int i = 0; i < dly; i++) begin
      step();
      chk({tag, "_hold"}, {query_valid, query_col, query_row},
          {1'b1, 4'(ecol), 5'(erow)});
    end
    query_occupied = occ;
    query_done     = 1'b1;
    step();
    query_done     = 1'b0;
    query_occupied = 1'b0;
    chk({tag, "_drop"}, query_valid, 0);
  endtask

  // Frame ticks with a board that is always free.
  task automatic run_frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      for (int c = 0; c < 6; c++) begin
        if (query_valid === 1'b1) begin
          query_done = 1'b1;
          query_occupied = 1'b0;
          step();
          query_done = 1'b0;
        end else begin
          step();
        end
      end
    end
  endtask

  task automatic press(input logic l, input logic r);
    left = l;
    right = r;
    step();
    left = 1'b0;
    right = 1'b0;
    step();
  endtask

  task automatic one_frame();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  initial begin
    // Reset values
    step();
    step();
    chk("rst_qv", query_valid, 0);
    chk("rst_active", active, 0);
    chk("rst_lock", lock_valid, 0);
    chk("rst_over", game_over, 0);
    chk("rst_color", color, COLOR_NONE);
    chk("rst_x", x_pos, 304);
    chk("rst_y", y_pos, 80);
    reset = 1'b0;
    step();

    // Start and spawn on a free board
    next_color = 3'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("spawnq_active", active, 0);
    serve("spawn", 1'b0, 1, 4, 0);
    step();
    chk("spawn_active", active, 1);
    chk("spawn_color", color, 5);
    chk("spawn_x", x_pos, 304);
    chk("spawn_y", y_pos, 80);

    // Gravity: 30 ticks -> row 1; 570 ticks from spawn -> bottom row
    run_frames(30);
    chk("grav1_y", y_pos, 96);
    chk("grav1_x", x_pos, 304);
    run_frames(540);
    chk("grav19_y", y_pos, 384);
    run_frames(29);
    next_color = 3'd6;
    one_frame();
    chk("bot_lock_valid", lock_valid, 1);
    chk("bot_lock_col", lock_col, 4);
    chk("bot_lock_row", lock_row, 19);
    chk("bot_lock_color", lock_color, 5);
    chk("bot_lock_noq", query_valid, 0);
    step();
    chk("bot_lock_once", lock_valid, 0);
    serve("respawn1", 1'b0, 1, 4, 0);
    step();
    chk("respawn1_color", color, 6);
    chk("respawn1_y", y_pos, 80);

    // Moves: right, five lefts to column 0
    press(1'b0, 1'b1);
    one_frame();
    serve("mv_right", 1'b0, 1, 5, 0);
    step();
    chk("mv_right_x", x_pos, 320);
    for (int k = 0; k < 5; k++) begin
      press(1'b1, 1'b0);
      one_frame();
      serve("mv_left", 1'b0, 2, 4 - k, 0);
    end
    step();
    chk("col0_x", x_pos, 240);

    // Left at column 0: no query
    press(1'b1, 1'b0);
    one_frame();
    step();
    step();
    chk("left_edge_noq", query_valid, 0);
    chk("left_edge_x", x_pos, 240);

    // Both sides in one frame: no move
    press(1'b1, 1'b1);
    one_frame();
    step();
    step();
    chk("both_noq", query_valid, 0);
    chk("both_x", x_pos, 240);

    // Right into an occupied cell: column unchanged
    press(1'b0, 1'b1);
    one_frame();
    serve("mv_blocked", 1'b1, 1, 1, 0);
    step();
    chk("mv_blocked_x", x_pos, 240);

    // Back to column 4 (gravity count now 13)
    for (int k = 0; k < 4; k++) begin
      press(1'b0, 1'b1);
      one_frame();
      serve("mv_back", 1'b0, 1, k + 1, 0);
    end
    step();
    chk("back_x", x_pos, 304);

    // Blocked fall at (4,6) -> lock (4,5), respawn query blocked -> game over
    run_frames(17);
    chk("fall_r1_y", y_pos, 96);
    run_frames(120);
    chk("fall_r5_y", y_pos, 160);
    run_frames(29);
    next_color = 3'd3;
    one_frame();
    serve("fall_blk", 1'b1, 2, 4, 6);
    chk("blk_lock_valid", lock_valid, 1);
    chk("blk_lock_col", lock_col, 4);
    chk("blk_lock_row", lock_row, 5);
    chk("blk_lock_color", lock_color, 6);
    step();
    chk("blk_lock_once", lock_valid, 0);
    serve("spawn_over", 1'b1, 1, 4, 0);
    chk("over_flag", game_over, 1);
    chk("over_active", active, 0);
    chk("over_color", color, 3);

    // Restart clears game_over
    next_color = 3'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_over", game_over, 0);
    serve("restart", 1'b0, 1, 4, 0);
    chk("restart_active", active, 1);
    chk("restart_color", color, 2);

    // Slow board: 7-cycle answer with stable request
    press(1'b0, 1'b1);
    one_frame();
    serve("slow", 1'b0, 7, 5, 0);
    step();
    chk("slow_x", x_pos, 320);

    // Reset in the middle of a query
    press(1'b1, 1'b0);
    one_frame();
    chk("mid_qv", query_valid, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_qv", query_valid, 0);
    chk("mid_rst_active", active, 0);
    chk("mid_rst_x", x_pos, 304);
    chk("mid_rst_color", color, COLOR_NONE);
    chk("mid_rst_over", game_over, 0);
    query_done = 1'b1;
    step();
    reset = 1'b0;
    step();
    step();
    query_done = 1'b0;
    chk("post_rst_qv", query_valid, 0);
    chk("post_rst_active", active, 0);
    chk("post_rst_lock", lock_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
